pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the enable and clear inputs of the PC register and of the F/D, D/E, E/M and M/W pipeline registers.
- Combines three inputs:
  - Tuse/Tnew data-hazard stalls.
  - A multi-cycle mult/div busy tracker, modelled as an FSM with a countdown.
  - Exception/eret flush requests from the M stage.
- Sits beside the datapath. It is purely a control block and holds no datapath values.

Parameters:
- MULT_CYC, 5, cycles HI/LO stay busy after a mult/multu start.
- DIV_CYC, 10, cycles HI/LO stay busy after a div/divu start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- D_rs_addr  input  5  rs register index of the D-stage instruction.
- D_rt_addr  input  5  rt register index of the D-stage instruction.
- D_rs_tuse  input  2  cycles until the D instruction needs rs; 3 means rs is unused.
- D_rt_tuse  input  2  cycles until the D instruction needs rt; 3 means rt is unused.
- D_is_md  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_wr_addr  input  5  destination register of the E-stage instruction.
- E_tnew  input  2  cycles until the E result is ready.
- M_wr_addr  input  5  destination register of the M-stage instruction.
- M_tnew  input  2  cycles until the M result is ready.
- E_md_start  input  1  E instruction is mult/multu/div/divu (one pulse per instruction).
- E_md_is_div  input  1  qualifies E_md_start as a divide.
- M_exc_req  input  1  exception or interrupt taken at M.
- M_eret  input  1  eret at M.
- PC_en  output  1  PC register load enable.
- FD_en  output  1  F/D register load enable.
- FD_flush  output  1  F/D synchronous clear.
- DE_flush  output  1  D/E synchronous clear (inserts a bubble).
- EM_flush  output  1  E/M synchronous clear.
- MW_flush  output  1  M/W synchronous clear.
- md_busy  output  1  HI/LO unit busy.
- stall  output  1  combined stall indication.

Behaviour:
- Reset: on a rising clk with reset=1, the FSM goes to IDLE, the countdown is cleared to 0, and md_busy=0. Reset has priority over every input, including a reset arriving while the unit is BUSY.
- Outputs immediately after reset: PC_en=1, FD_en=1, all flushes=0, stall=0, provided the inputs show no hazard.
- Data stall (combinational):
  - rs_stall = (D_rs_addr!=0) && ((E_wr_addr==D_rs_addr && E_tnew>D_rs_tuse) || (M_wr_addr==D_rs_addr && M_tnew>D_rs_tuse)).
  - rt_stall is defined the same way using D_rt_addr and D_rt_tuse.
  - Register $0 never stalls.
  - A Tuse of 3 never stalls, because Tnew is at most 2.
- MD FSM:
  - States are IDLE and BUSY.
  - In IDLE, E_md_start=1 moves to BUSY and loads the countdown with (E_md_is_div ? DIV_CYC : MULT_CYC).
  - In BUSY, the countdown decrements each cycle. When it reaches 1, the FSM returns to IDLE on the next edge.
  - md_busy = (state==BUSY) || E_md_start.
  - md_stall = D_is_md && md_busy.
  - E_md_start seen while already BUSY is ignored. This cannot legally occur, because the start instruction would have been stalled in D.
- stall = rs_stall || rt_stall || md_stall.
- During a stall: PC_en=0, FD_en=0, DE_flush=1. E/M and M/W keep advancing.
- Flush: if M_exc_req || M_eret:
  - FD_flush=1, DE_flush=1, EM_flush=1 in that same cycle.
  - PC_en=1 and FD_en=1, so the flush overrides the stall.
  - MW_flush=0, so the M instruction still retires.
- A flush does not abort an md operation already in BUSY. HI/LO completes in the background and the countdown continues.
- Output latency: zero-cycle combinational, from registered state plus the current inputs.
- The countdown is 4 bits wide; DIV_CYC and MULT_CYC must each be ≤15.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined:
  - Adds the outputs stall_cycles[31:0] and flush_count[15:0].
  - stall_cycles increments on every cycle where stall=1 and no flush is active.
  - flush_count increments on every cycle where (M_exc_req||M_eret)=1.
  - Both counters are cleared by reset and wrap modulo 2^n without saturating.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Load-use hazard:
  - Stimulus: E_wr_addr=8, E_tnew=2, D_rs_addr=8, D_rs_tuse=1, then E_tnew drops to 0 the next cycle.
  - Response: stall=1, PC_en=0, FD_en=0, DE_flush=1 for exactly one cycle, then stall=0.
- $0 and unused operands:
  - Stimulus: E_wr_addr=0 with D_rs_addr=0 and E_tnew=2; separately, D_rt_tuse=3 with an rt match.
  - Response: stall=0 in both cases.
- Divide busy:
  - Stimulus: pulse E_md_start with E_md_is_div=1, and hold D_is_md=1.
  - Response: md_busy=1 for 11 consecutive cycles (the start cycle plus 10 BUSY cycles) and stall=1 throughout, then md_busy=0 and stall=0.
- Exception during a stall:
  - Stimulus: hold a load-use stall and pulse M_exc_req for one cycle.
  - Response: that cycle shows PC_en=1, FD_en=1, FD_flush=1, DE_flush=1, EM_flush=1, MW_flush=0.
- Reset mid-divide:
  - Stimulus: assert reset three cycles after a div start.
  - Response: on the next edge md_busy=0 and the FSM is in IDLE; with D_is_md=1, stall=0.
- STALL_PERF_CNT_EN:
  - Stimulus: apply 7 stall cycles and 2 eret pulses.
  - Response: stall_cycles=7 and flush_count=2; both read 0 after reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Optional perf counters under `STALL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic [4:0]  E_wr_addr,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wr_addr,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        M_exc_req,
  input  logic        M_eret,
  output logic        PC_en,
  output logic        FD_en,
  output logic        FD_flush,
  output logic        DE_flush,
  output logic        EM_flush,
  output logic        MW_flush,
  output logic        md_busy,
  output logic        stall
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  localparam logic [3:0] LP_MULT = MULT_CYC[3:0];
  localparam logic [3:0] LP_DIV  = DIV_CYC[3:0];

  md_state_t  r_state;
  md_state_t  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_rs_stall;
  logic w_rt_stall;
  logic w_md_stall;
  logic w_md_busy;
  logic w_stall;
  logic w_flush;

  always_comb begin
    w_rs_stall = (D_rs_addr != 5'd0) &&
      ((E_wr_addr == D_rs_addr && E_tnew > D_rs_tuse) ||
       (M_wr_addr == D_rs_addr && M_tnew > D_rs_tuse));
    w_rt_stall = (D_rt_addr != 5'd0) &&
      ((E_wr_addr == D_rt_addr && E_tnew > D_rt_tuse) ||
       (M_wr_addr == D_rt_addr && M_tnew > D_rt_tuse));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Starts arriving while BUSY are dropped; D would have stalled them.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (E_md_start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = E_md_is_div ? LP_DIV : LP_MULT;
        end
      end
      S_BUSY: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_md_busy  = (r_state == S_BUSY) || E_md_start;
    w_md_stall = D_is_md && w_md_busy;
    w_stall    = w_rs_stall || w_rt_stall || w_md_stall;
    w_flush    = M_exc_req || M_eret;
  end

  // Flush wins over stall; M still retires.
  always_comb begin
    PC_en    = !w_stall || w_flush;
    FD_en    = !w_stall || w_flush;
    FD_flush = w_flush;
    DE_flush = w_stall || w_flush;
    EM_flush = w_flush;
    MW_flush = 1'b0;
    md_busy  = w_md_busy;
    stall    = w_stall;
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (w_stall && !w_flush)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush)
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule
